// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state type for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int ARB_STATE_W = 2;
  localparam int BE_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants taken while a fetch was waiting.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data ports.
// Data wins ties unless fetch has been starved long enough.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = WORD_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [W-1:0]    if_addr,
  output logic            if_ack,
  output logic [W-1:0]    if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [W-1:0]    d_addr,
  input  logic [W-1:0]    d_wdata,
  input  logic [BE_W-1:0] d_be,
  output logic            d_ack,
  output logic [W-1:0]    d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [W-1:0]    mem_addr,
  output logic [W-1:0]    mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [W-1:0]    mem_rdata,
  output logic            busy
);

  arb_state_e state_q, state_d;

  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [W-1:0]    mem_addr_q, mem_addr_d;
  logic [W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0] mem_be_q, mem_be_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [W-1:0]    if_rdata_q, if_rdata_d;
  logic [W-1:0]    d_rdata_q, d_rdata_d;

  logic in_idle;
  logic if_elig;
  logic d_elig;
  logic sat;
  logic grant_i;
  logic grant_d;

  // A port whose ack is still showing is not eligible again yet.
  assign in_idle = (state_q == ARB_IDLE);
  assign if_elig = if_req && !if_ack_q;
  assign d_elig  = d_req && !d_ack_q;
  assign grant_i = in_idle && if_elig && (!d_elig || sat);
  assign grant_d = in_idle && d_elig && !grant_i;

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(grant_d && if_elig),
    .clr(grant_i),
    .sat(sat)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        unique case (1'b1)
          grant_i: begin
            state_d    = ARB_BUSY_I;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            mem_be_d   = '1;
          end
          grant_d: begin
            state_d     = ARB_BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end
          default: ;
        endcase
      end
      ARB_BUSY_I: begin
        if (mem_ack) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ack) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          d_ack_d   = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random
// requesters and memory against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int W = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic if_req, d_req, d_we, mem_ack;
  logic [W-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0] d_be;
  logic if_ack, d_ack, mem_req, mem_we, busy;
  logic [W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;

  int checks = 0;
  int errors = 0;

  // model: who owns the bus (0 none, 1 fetch, 2 data) and what it shows
  int owner;
  int starve;
  logic e_if_ack, e_d_ack, e_we;
  logic [W-1:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
  logic [3:0] e_be;

  mem_port_arbiter #(.W(W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    owner = 0;
    starve = 0;
    e_if_ack = 0; e_d_ack = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_be = '0;
    e_if_rdata = '0; e_d_rdata = '0;
  endtask

  // Advance the model by one clock using the inputs now applied.
  task automatic model_next();
    bit el_i, el_d;
    if (!rst) begin
      reset_model();
      return;
    end
    el_i = if_req && !e_if_ack;
    el_d = d_req && !e_d_ack;
    e_if_ack = 0;
    e_d_ack = 0;
    if (owner == 0) begin
      if (el_i && (!el_d || starve == SMAX)) begin
        owner = 1;
        starve = 0;
        e_we = 0; e_addr = if_addr; e_be = 4'hf;
      end else if (el_d) begin
        owner = 2;
        if (el_i && starve < SMAX) starve++;
        e_we = d_we; e_addr = d_addr;
        e_wdata = d_wdata; e_be = d_be;
      end
    end else if (mem_ack) begin
      if (owner == 1) begin
        e_if_ack = 1;
        e_if_rdata = mem_rdata;
      end else begin
        e_d_ack = 1;
        if (!e_we) e_d_rdata = mem_rdata;
      end
      owner = 0;
    end
  endtask

  task automatic check_all();
    chk("mem_req", W'(mem_req), W'(owner != 0));
    chk("busy", W'(busy), W'(owner != 0));
    chk("if_ack", W'(if_ack), W'(e_if_ack));
    chk("d_ack", W'(d_ack), W'(e_d_ack));
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    if (owner != 0) begin
      chk("mem_we", W'(mem_we), W'(e_we));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_be", W'(mem_be), W'(e_be));
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
  endtask

  task automatic tick();
    model_next();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1;
    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    d_be = '0; mem_rdata = '0;
    reset_model();
    #1 rst = 0;
    repeat (2) tick();
    rst = 1;
    tick();

    // reset in the middle of a load
    d_req = 1; d_we = 0; d_addr = 32'h100;
    tick();
    chk("rst_pre_req", W'(mem_req), 1);
    tick();
    #2 rst = 0;
    #1;
    chk("rst_req_drop", W'(mem_req), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_d_ack", W'(d_ack), 0);
    reset_model();
    d_req = 0;
    tick();
    rst = 1;
    tick();

    // single fetch with three-cycle memory latency
    if_req = 1; if_addr = 32'h40;
    tick();
    tick();
    tick();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t2_if_ack", W'(if_ack), 1);
    chk("t2_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 0; mem_ack = 0; mem_rdata = 32'h5555AAAA;
    tick();
    chk("t2_ack_once", W'(if_ack), 0);
    chk("t2_rdata_hold", if_rdata, 32'hDEADBEEF);

    // store acked in its first bus cycle
    d_req = 1; d_we = 1; d_addr = 32'h80;
    d_wdata = 32'h12345678; d_be = 4'b0011;
    tick();
    chk("t3_we", W'(mem_we), 1);
    chk("t3_be", W'(mem_be), W'(4'b0011));
    mem_ack = 1;
    tick();
    chk("t3_d_ack", W'(d_ack), 1);
    chk("t3_d_rdata", d_rdata, 0);
    d_req = 0; mem_ack = 0;
    tick();

    // simultaneous requests; data keeps req high through its ack
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    tick();
    chk("t4_data_first", mem_addr, 32'h300);
    mem_ack = 1; mem_rdata = 32'hCAFE0001;
    tick();
    chk("t4_d_ack", W'(d_ack), 1);
    mem_ack = 0;
    tick();
    chk("t4_fetch_next", mem_addr, 32'h200);
    d_req = 0;
    mem_ack = 1; mem_rdata = 32'hCAFE0002;
    tick();
    chk("t4_if_ack", W'(if_ack), 1);
    if_req = 0; mem_ack = 0;
    tick();
    chk("t6_no_regrant", W'(mem_req), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (if_req && e_if_ack) begin
        if_req = ($urandom_range(0, 1) == 1);
        if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = $urandom;
      end
      if (d_req && e_d_ack) begin
        d_req = ($urandom_range(0, 1) == 1);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom);
      end else if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1;
        d_we = $urandom_range(0, 1) == 1;
        d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom);
      end
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port memory bus between the instruction-fetch port (IF) and the data load/store port (MEM stage).
- Serializes requests, holds the bus stable until the memory acknowledges, and returns read data with a one-cycle ack pulse to the winning requester.
- Fixed priority favours data. A starvation counter forces a fetch grant after STARVE_MAX consecutive data wins.
- Sits between the cpu's pc/load/store ports and a unified memory controller.

Parameters:
W, `WORD_WIDTH (32), data/address width
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced; range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held high until if_ack
if_addr  in  W  fetch address; stable while if_req
if_ack  out  1  one-cycle completion pulse
if_rdata  out  W  fetched word; valid with if_ack, held until next fetch completes
d_req  in  1  data request; held high until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  W  data address
d_wdata  in  W  store data
d_be  in  4  byte enables
d_ack  out  1  one-cycle completion pulse
d_rdata  out  W  load data; valid with d_ack, held until next load completes
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  W  bus address
mem_wdata  out  W  bus write data
mem_be  out  4  bus byte enables
mem_ack  in  1  memory completion; for reads, mem_rdata is valid in the same cycle
mem_rdata  in  W  memory read data
busy  out  1  high in any non-IDLE state

Behaviour:
Reset (rst=0, asynchronous):
- All outputs go to 0; state=IDLE; starve_cnt=0.
- An in-flight mem_req drops immediately. The memory side must tolerate the abort.

States:
- IDLE, BUSY_I, BUSY_D. Encoding is 2 bits.

Eligibility in IDLE:
- Port eligible = req & ~ack_out_this_cycle. This prevents re-granting a request whose ack pulse is still visible.

Grant in IDLE:
- Only data eligible: go to BUSY_D.
- Only fetch eligible: go to BUSY_I.
- Both eligible:
  - starve_cnt==STARVE_MAX: go to BUSY_I.
  - Otherwise: go to BUSY_D.
- On grant, latch addr/we/wdata/be into bus registers. mem_req=1 from the next cycle.

Starvation counter:
- Granting D while fetch is eligible: starve_cnt+1, saturating at STARVE_MAX.
- Granting I: starve_cnt reset to 0.

Bus hold:
- In BUSY_x, mem_req and all mem_* outputs are registered and constant until mem_ack=1.

On mem_ack in BUSY_x:
- Next cycle: x_ack=1 for exactly one cycle; state=IDLE; mem_req=0.
- For a fetch or load, capture mem_rdata into x_rdata.
- Stores leave d_rdata unchanged.
- For a fetch, mem_we=0 and mem_be=4'b1111.

Latency:
- Request seen in IDLE at cycle N: mem_req high at N+1.
- mem_ack at cycle M>=N+1: ack pulse at M+1.
- Minimum 2 cycles per transaction, with an IDLE cycle between back-to-back transactions.

Other rules:
- mem_ack while IDLE is ignored.
- The requester may drop req only after its ack. Dropping req mid-transaction does not abort; the ack is still issued.
- Simultaneous requests in the same cycle follow the grant rules above; there are no ties.

Decomposition:
- Add to defines.v: `ARB_IDLE/`ARB_BUSY_I/`ARB_BUSY_D state constants, `ARB_STATE_W=2, `BE_W=4.
- One sub-module, arb_starve_counter: saturating counter with inc/clr/sat outputs.
- The FSM, bus registers and rdata capture stay in mem_port_arbiter.

Test Plan:
1. Reset mid-operation:
   - Stimulus: d_req load 0x100; memory acks after 3 cycles; assert rst low during the 2nd wait cycle.
   - Response: mem_req=0 immediately; no d_ack; state IDLE; after release, a new request completes normally.
2. Single fetch:
   - Stimulus: if_req at cycle 0, addr 0x40; mem_ack at cycle 3 with mem_rdata 0xDEADBEEF.
   - Response: mem_req high cycles 1–3; if_ack at cycle 4 only; if_rdata=0xDEADBEEF held afterwards.
3. Store:
   - Stimulus: d_we=1, addr 0x80, wdata 0x12345678, be 4'b0011; memory acks immediately.
   - Response: mem_we=1, mem_be=0011, wdata stable while mem_req; d_ack one cycle later; d_rdata unchanged.
4. Simultaneous requests:
   - Stimulus: if_req and d_req rise together.
   - Response: data served first; fetch granted in the IDLE cycle after d_ack; no duplicate data grant.
5. Starvation:
   - Stimulus: if_req held; d_req re-asserted continuously for 6 transactions; STARVE_MAX=4.
   - Response: grant order D,D,D,D,I,D; starve_cnt returns to 0 after the I grant.
6. Ack-cycle re-grant guard:
   - Stimulus: requester keeps d_req high during its d_ack cycle, then drops it.
   - Response: exactly one bus transaction.
